// File: rtl/pis_pkg.sv
// Shared types and packet-length helpers for the pis_mc readout block.
// Packet length grows by one parity bit when PIS_PARITY_EN is defined.
package pis_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } pis_state_t;

    localparam logic START_BIT = 1'b1;

    function automatic int pkt_len(input int ch_w, input int data_w);
`ifdef PIS_PARITY_EN
        return ch_w + data_w + 2;
`else
        return ch_w + data_w + 1;
`endif
    endfunction

    function automatic int pkt_body_len(input int ch_w, input int data_w);
        return pkt_len(ch_w, data_w) - 1;
    endfunction

endpackage

// File: rtl/pis_fifo.sv
// Synchronous FIFO holding {ch_id, data} words; DEPTH must be a power of 2.
// Push is ignored when full and pop when empty, so there is no bypass path.
module pis_fifo #(
    parameter int WIDTH = 30,
    parameter int DEPTH = 4
) (
    input  logic                     clk_40MHz,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk_40MHz) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk_40MHz) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/pis_mc.sv
// Multi-channel parallel-in/serial-out readout: round-robin arbiter, FIFO, serializer.
// Define PIS_PARITY_EN to append an even-parity bit over ID+data to each packet.
//
// state | meaning
// IDLE  | no packet on the line; pop and load as soon as the FIFO holds a word
// SHIFT | one packet bit per cycle; on the last bit reload back-to-back if possible
module pis_mc
    import pis_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int DATA_W     = 28,
    parameter int FIFO_DEPTH = 4,
    parameter int CH_W       = $clog2(N_CH)
) (
    input  logic                          clk_40MHz,
    input  logic                          rst,
    input  logic                          shake_hands_en,
    input  logic [N_CH-1:0]               ch_valid,
    input  logic [N_CH*DATA_W-1:0]        ch_data,
    output logic [N_CH-1:0]               ch_ready,
    output logic                          valid_out,
    output logic                          data_out,
    output logic                          frame_start,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int L     = pkt_len(CH_W, DATA_W);
    localparam int BODY  = pkt_body_len(CH_W, DATA_W);
    localparam int CNT_W = $clog2(L);
    localparam int FW    = CH_W + DATA_W;

    logic [CH_W-1:0]  rr_ptr;
    logic [CH_W-1:0]  scan_id;
    logic [CH_W-1:0]  grant_id;
    logic             transfer;
    logic [FW-1:0]    push_word;
    logic [FW-1:0]    head_word;
    logic             fifo_full;
    logic             fifo_empty;
    logic             load;
    logic [BODY-1:0]  body;
    logic [BODY-1:0]  shreg;
    logic [CNT_W-1:0] bit_cnt;
    pis_state_t       state;
    pis_state_t       state_nxt;

    // First requester at or after rr_ptr wins; no grants in reset or when full.
    always_comb begin
        ch_ready = '0;
        grant_id = '0;
        scan_id  = '0;
        transfer = 1'b0;
        if (!rst && shake_hands_en && !fifo_full) begin
            for (int k = 0; k < N_CH; k++) begin
                scan_id = CH_W'((int'(rr_ptr) + k) % N_CH);
                if (!transfer && ch_valid[scan_id]) begin
                    transfer          = 1'b1;
                    ch_ready[scan_id] = 1'b1;
                    grant_id          = scan_id;
                end
            end
        end
    end

    assign push_word = {grant_id, ch_data[int'(grant_id)*DATA_W +: DATA_W]};

    always_ff @(posedge clk_40MHz) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (transfer) begin
            rr_ptr <= (int'(grant_id) == N_CH - 1) ? '0 : grant_id + CH_W'(1);
        end
    end

    pis_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_40MHz (clk_40MHz),
        .rst       (rst),
        .push      (transfer),
        .pop       (load),
        .wdata     (push_word),
        .rdata     (head_word),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

`ifdef PIS_PARITY_EN
    assign body = {head_word, ^head_word};
`else
    assign body = head_word;
`endif

    always_ff @(posedge clk_40MHz) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt == '0) begin
                    if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // data_out carries the current bit; shreg holds the bits still to come.
    always_ff @(posedge clk_40MHz) begin
        if (rst) begin
            shreg       <= '0;
            bit_cnt     <= '0;
            valid_out   <= 1'b0;
            data_out    <= 1'b0;
            frame_start <= 1'b0;
        end else if (load) begin
            shreg       <= body;
            bit_cnt     <= CNT_W'(L - 1);
            valid_out   <= 1'b1;
            data_out    <= START_BIT;
            frame_start <= 1'b1;
        end else if (state == SHIFT && bit_cnt != '0) begin
            shreg       <= {shreg[BODY-2:0], 1'b0};
            bit_cnt     <= bit_cnt - CNT_W'(1);
            valid_out   <= 1'b1;
            data_out    <= shreg[BODY-1];
            frame_start <= 1'b0;
        end else begin
            valid_out   <= 1'b0;
            data_out    <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pis_mc.sv
// Directed bench for pis_mc: a per-channel source model feeds words, outputs are
// logged every cycle at the falling edge and compared against hand-computed packets.
module tb_pis_mc;

`ifdef PIS_PARITY_EN
    localparam int L = 32;
`else
    localparam int L = 31;
`endif
    localparam int LOG_N = 2048;

    logic         clk_40MHz = 1'b0;
    logic         rst = 1'b1;
    logic         shake_hands_en = 1'b1;
    logic [3:0]   ch_valid = '0;
    logic [111:0] ch_data = '0;
    logic [3:0]   ch_ready;
    logic         valid_out;
    logic         data_out;
    logic         frame_start;
    logic [2:0]   fifo_level;

    pis_mc dut (
        .clk_40MHz      (clk_40MHz),
        .rst            (rst),
        .shake_hands_en (shake_hands_en),
        .ch_valid       (ch_valid),
        .ch_data        (ch_data),
        .ch_ready       (ch_ready),
        .valid_out      (valid_out),
        .data_out       (data_out),
        .frame_start    (frame_start),
        .fifo_level     (fifo_level)
    );

    always #12 clk_40MHz = ~clk_40MHz;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0;

    typedef logic [27:0] word_q_t[$];
    word_q_t src_q [4];

    logic [3:0] gnt_now = '0;
    logic       vo_log  [LOG_N];
    logic       d_log   [LOG_N];
    logic       fs_log  [LOG_N];
    logic [3:0] rdy_log [LOG_N];
    logic [3:0] gnt_log [LOG_N];
    logic [2:0] lvl_log [LOG_N];

    int         gcyc[$];
    logic [3:0] gval[$];

    always @(negedge clk_40MHz) begin
        gnt_now = ch_valid & ch_ready;
        if (cyc < LOG_N) begin
            vo_log[cyc]  = valid_out;
            d_log[cyc]   = data_out;
            fs_log[cyc]  = frame_start;
            rdy_log[cyc] = ch_ready;
            gnt_log[cyc] = ch_valid & ch_ready;
            lvl_log[cyc] = fifo_level;
        end
    end

    // Source model: retire granted words after the edge, then present the next ones.
    always @(posedge clk_40MHz) begin
        cyc++;
        #2;
        for (int i = 0; i < 4; i++) begin
            if (gnt_now[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            ch_valid[i] = (src_q[i].size() > 0);
            ch_data[i*28 +: 28] = (src_q[i].size() > 0) ? src_q[i][0] : 28'h0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle(input int n);
        repeat (n) @(posedge clk_40MHz);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        next_cycle(2);
        rst = 1'b0;
    endtask

    function automatic logic [63:0] grab(input int start, input int len);
        logic [63:0] v = '0;
        for (int k = 0; k < len; k++) v = {v[62:0], d_log[start+k]};
        return v;
    endfunction

    function automatic int count_vo(input int a, input int b);
        int n = 0;
        for (int c = a; c <= b; c++) if (vo_log[c] === 1'b1) n++;
        return n;
    endfunction

    function automatic int count_fs(input int a, input int b);
        int n = 0;
        for (int c = a; c <= b; c++) if (fs_log[c] === 1'b1) n++;
        return n;
    endfunction

    function automatic int count_rdy(input int a, input int b);
        int n = 0;
        for (int c = a; c <= b; c++) if (rdy_log[c] !== 4'b0000) n++;
        return n;
    endfunction

    function automatic logic [63:0] exp_pkt(input logic [1:0] id, input logic [27:0] data);
        logic [63:0] v;
        v = {33'd0, 1'b1, id, data};
`ifdef PIS_PARITY_EN
        v = {v[62:0], ^{id, data}};
`endif
        return v;
    endfunction

    initial begin
        #(1500 * 24);
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g4, g5, g6, max_lvl;

        // Reset state
        next_cycle(3);
        @(negedge clk_40MHz);
        check("rst_valid_out", valid_out, 0);
        check("rst_data_out", data_out, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_ch_ready", ch_ready, 0);
        check("rst_fifo_level", fifo_level, 0);
        next_cycle(1);
        rst = 1'b0;
        next_cycle(2);

        // Single word on ch2
        t0 = cyc;
        src_q[2].push_back(28'h0ABCDEF);
        next_cycle(40);
        check("t1_ready_c0", rdy_log[t0], 4'b0100);
        check("t1_level_c1", lvl_log[t0+1], 1);
        check("t1_level_c2", lvl_log[t0+2], 0);
        check("t1_valid_c1", vo_log[t0+1], 0);
        check("t1_fs_c2", fs_log[t0+2], 1);
        check("t1_fs_count", count_fs(t0, t0+38), 1);
        check("t1_valid_span", count_vo(t0+2, t0+L+1), L);
        check("t1_valid_after", vo_log[t0+L+2], 0);
        check("t1_stream", grab(t0+2, L), exp_pkt(2'd2, 28'h0ABCDEF));

        // Two words on ch0, back to back
        t0 = cyc;
        src_q[0].push_back(28'h1234567);
        src_q[0].push_back(28'h7654321);
        next_cycle(2*L + 10);
        check("t2_ready_c0", rdy_log[t0], 4'b0001);
        check("t2_ready_c1", rdy_log[t0+1], 4'b0001);
        check("t2_valid_total", count_vo(t0, t0+2*L+9), 2*L);
        check("t2_valid_span", count_vo(t0+2, t0+2*L+1), 2*L);
        check("t2_fs_first", fs_log[t0+2], 1);
        check("t2_fs_second", fs_log[t0+L+2], 1);
        check("t2_fs_count", count_fs(t0, t0+2*L+9), 2);
        check("t2_stream_a", grab(t0+2, L), exp_pkt(2'd0, 28'h1234567));
        check("t2_stream_b", grab(t0+L+2, L), exp_pkt(2'd0, 28'h7654321));

        // All four channels busy: round robin, full FIFO, continuous output
        do_reset();
        t0 = cyc;
        for (int i = 0; i < 4; i++)
            for (int w = 0; w < 3; w++) src_q[i].push_back(28'(28'h0A00000 + i*256 + w));
        next_cycle(12*L + 10);
        for (int c = t0; c < t0 + 12*L + 10; c++) begin
            if (gnt_log[c] !== 4'b0000) begin
                gcyc.push_back(c);
                gval.push_back(gnt_log[c]);
            end
        end
        check("t3_grant_count", gcyc.size(), 12);
        for (int j = 0; j < gval.size() && j < 12; j++)
            check($sformatf("t3_grant_%0d", j), gval[j], 4'b0001 << (j % 4));
        g4 = (gcyc.size() > 4) ? gcyc[4] : -1;
        g5 = (gcyc.size() > 5) ? gcyc[5] : -1;
        g6 = (gcyc.size() > 6) ? gcyc[6] : -1;
        check("t3_grant4_cycle", g4 - t0, 4);
        check("t3_grant5_after_pop", g5 - t0, L + 2);
        check("t3_grant_spacing", g6 - g5, L);
        max_lvl = 0;
        for (int c = t0; c < t0 + 12*L + 10; c++) if (int'(lvl_log[c]) > max_lvl) max_lvl = int'(lvl_log[c]);
        check("t3_max_level", max_lvl, 4);
        check("t3_level_full_c5", lvl_log[t0+5], 4);
        check("t3_valid_continuous", count_vo(t0+2, t0+12*L+1), 12*L);
        check("t3_valid_after", vo_log[t0+12*L+2], 0);
        check("t3_stream_p0", grab(t0+2, L), exp_pkt(2'd0, 28'h0A00000));
        check("t3_stream_p1", grab(t0+2+L, L), exp_pkt(2'd1, 28'h0A00100));
        check("t3_stream_p4", grab(t0+2+4*L, L), exp_pkt(2'd0, 28'h0A00001));
        check("t3_level_end", lvl_log[t0+12*L+5], 0);

        // Readout disabled with three words already accepted
        t0 = cyc;
        src_q[1].push_back(28'h0111111);
        src_q[2].push_back(28'h0222222);
        src_q[3].push_back(28'h0333333);
        next_cycle(3);
        shake_hands_en = 1'b0;
        src_q[0].push_back(28'h0DEAD00);
        next_cycle(3*L + 12);
        check("t4_grants_before", count_rdy(t0, t0+2), 3);
        check("t4_level_c3", lvl_log[t0+3], 2);
        check("t4_no_ready", count_rdy(t0+3, t0+3*L+13), 0);
        check("t4_valid_span", count_vo(t0+2, t0+3*L+1), 3*L);
        check("t4_valid_after", vo_log[t0+3*L+2], 0);
        check("t4_stream_last", grab(t0+2+2*L, L), exp_pkt(2'd3, 28'h0333333));
        check("t4_level_end", lvl_log[t0+3*L+10], 0);
        check("t4_word_held", src_q[0].size(), 1);
        src_q[0].delete();
        next_cycle(2);
        shake_hands_en = 1'b1;
        next_cycle(1);

        // Reset at bit 10 of a packet with two words buffered
        t0 = cyc;
        src_q[0].push_back(28'h0EEEEEE);
        src_q[1].push_back(28'h0FFFFFF);
        src_q[2].push_back(28'h0CCCCCC);
        next_cycle(12);
        rst = 1'b1;
        next_cycle(1);
        rst = 1'b0;
        next_cycle(1);
        src_q[3].push_back(28'h0333000);
        src_q[1].push_back(28'h0123ABC);
        next_cycle(L + 8);
        check("t5_level_before", lvl_log[t0+12], 2);
        check("t5_valid_before", vo_log[t0+12], 1);
        check("t5_valid_after_rst", vo_log[t0+13], 0);
        check("t5_level_after_rst", lvl_log[t0+13], 0);
        check("t5_idle_gap", count_vo(t0+13, t0+15), 0);
        check("t5_rr_reset_grant", rdy_log[t0+14], 4'b0010);
        check("t5_next_grant", rdy_log[t0+15], 4'b1000);
        check("t5_fs_new", fs_log[t0+16], 1);
        check("t5_stream_new", grab(t0+16, L), exp_pkt(2'd1, 28'h0123ABC));

`ifdef PIS_PARITY_EN
        // Parity build: ID 1 with data 1 gives an even-parity bit of 0
        do_reset();
        next_cycle(L + 4);
        t0 = cyc;
        src_q[1].push_back(28'h0000001);
        next_cycle(L + 6);
        check("t6_stream", grab(t0+2, L), {32'd0, 1'b1, 2'b01, 28'h0000001, 1'b0});
        check("t6_parity_bit", d_log[t0+L+1], 0);
        check("t6_length", count_vo(t0+2, t0+L+5), 32);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pis_mc.md
# pis_mc

Parametrised multi-channel parallel-in/serial-out readout block. It is the successor of the single-channel 28-bit PIS stage. It accepts data words from `N_CH` column-group readout ports over a valid/ready (shake-hands) handshake and arbitrates between them round-robin. Accepted words are buffered in a `FIFO_DEPTH`-entry FIFO. Each word is emitted as a self-framed serial packet that carries its channel ID. The block sits between the pixel-array data route and the output pad/LVDS driver.

## Interface
Parameters:
- `N_CH`, 4: number of readout channels, ≥2.
- `DATA_W`, 28: bits per channel word.
- `FIFO_DEPTH`, 4: FIFO entries, power of 2, ≥2.
- `CH_W`, derived as `$clog2(N_CH)`: channel-ID field width.

Ports (all synchronous to `clk_40MHz`; one clock; reset is synchronous and active-high):
- `clk_40MHz` in 1: block clock.
- `rst` in 1: synchronous active-high reset.
- `shake_hands_en` in 1: global readout enable, from SPI OR pad.
- `ch_valid` in N_CH: channel i holds a word.
- `ch_data` in N_CH*DATA_W: channel i word at `[i*DATA_W +: DATA_W]`.
- `ch_ready` out N_CH: one-hot grant; a word transfers when `ch_valid[i] & ch_ready[i]`.
- `valid_out` out 1: high on every serial bit of a packet.
- `data_out` out 1: serial bit, MSB first.
- `frame_start` out 1: high on the start bit only.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current occupancy.

## Operation
- Packet, MSB first: start bit `1`, then channel ID (CH_W bits), then data (DATA_W bits), then a parity bit if `PIS_PARITY_EN`. Length L = 1+CH_W+DATA_W(+1); defaults give L=31 (or 32).
- Arbiter:
  - Asserts at most one `ch_ready` per cycle.
  - Grants only if `shake_hands_en`=1 and FIFO not full.
  - Granted channel is the first requester at or after `rr_ptr`, searching upward with wrap.
  - After a transfer on channel i, `rr_ptr` ← (i+1) mod N_CH.
  - `ch_ready` may depend combinationally on `ch_valid`.
- FIFO:
  - Stores {ch_id, data}.
  - Push happens only when not full, so a full FIFO blocks a push even if a pop occurs in the same cycle (no bypass).
  - Pop and push in the same cycle are allowed when not full; `fifo_level` is then unchanged.
- Serializer FSM, states IDLE and SHIFT:
  - IDLE: if FIFO not empty, pop, load the shift register and bit counter (L-1), then go to SHIFT.
  - SHIFT: drive one bit per cycle.
  - On the last bit (counter=0): if FIFO not empty, pop and reload so the next packet follows with no gap; otherwise return to IDLE.
- `shake_hands_en` low only blocks new grants. The packet in flight and the FIFO contents still drain.
- Reset, on any cycle including mid-packet:
  - `valid_out`, `data_out`, `frame_start`, `ch_ready`, `fifo_level` = 0.
  - FSM goes to IDLE, FIFO is emptied, `rr_ptr`=0.
  - A partial packet is truncated and never resumed.
- Simultaneous transfer and serializer demand on an empty FIFO: the word takes the normal FIFO path (+1 cycle); there is no bypass.

## Timing
- `valid_out`, `data_out`, `frame_start` are registered outputs.
- Transfer in cycle t → FIFO non-empty at t+1 → pop in t+1 → start bit on outputs at t+2.
- Packet occupies exactly L consecutive cycles. Back-to-back packets give continuous `valid_out`.
- Sustained throughput is one word per L cycles. With the FIFO full, `ch_ready` re-asserts the cycle after a pop.
- `fifo_level` is updated the cycle after a push or pop.

## Configuration
- `PIS_PARITY_EN` defined: append one even-parity bit over ID+data, so L = CH_W+DATA_W+2.
- `PIS_PARITY_EN` undefined: no parity bit, so L = CH_W+DATA_W+1.

## Structure
- Package `pis_pkg` holds:
  - FSM state typedef (IDLE, SHIFT).
  - Start-bit constant.
  - Functions computing L from CH_W/DATA_W.
- Sub-module `pis_fifo`: synchronous FIFO parametrised by width (CH_W+DATA_W) and depth. It provides full, empty and level outputs.
- Arbiter and serializer stay in `pis_mc`.

## Test plan
(Default parameters, parity off unless stated.)
- Single word, ch 2, `28'h0ABCDEF`, in cycle 0:
  - `ch_ready`=4'b0100 in cycle 0.
  - `frame_start`=1 in cycle 2.
  - Bit stream `1`,`10`,`0000_1010_1011_1100_1101_1110_1111`.
  - `valid_out` high for cycles 2–32.
- All 4 channels valid continuously:
  - Grants in order 0,1,2,3,0,…
  - FIFO reaches level 4 and then accepts one word per 31 cycles.
  - `valid_out` never drops.
- Two words on ch 0: packets are contiguous, with `valid_out` high for 62 cycles and `frame_start` at cycles 2 and 33.
- `shake_hands_en`=0 with 3 words already buffered:
  - `ch_ready`=0 throughout.
  - All 3 packets still emitted, then `fifo_level`=0 and the FSM goes to IDLE.
- `rst` pulsed at bit 10 of a packet while FIFO level=2:
  - Next cycle: `valid_out`=0, `fifo_level`=0, `rr_ptr`=0.
  - A new word after reset emits normally.
- `PIS_PARITY_EN`, ch 1, data `28'h0000001`: L=32 and the last bit = 0 (ID 1 + data 1 gives even parity).
